// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// read+write at full, and a synchronous flush. All outputs are registered.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [CNT_W-1:0]  count_next;

    // Occupancy after one edge; a simultaneous accepted read and write cancel.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] c,
        input logic             w,
        input logic             r
    );
        logic [CNT_W-1:0] n;
        n = c;
        if (w && !r)
            n = c + CNT_W'(1);
        else if (r && !w)
            n = c - CNT_W'(1);
        return n;
    endfunction

    function automatic logic is_full(input logic [CNT_W-1:0] c);
        return c == CNT_W'(DEPTH);
    endfunction

    function automatic logic is_almost_full(input logic [CNT_W-1:0] c);
        return c >= CNT_W'(AF_THRESH);
    endfunction

    function automatic logic is_almost_empty(input logic [CNT_W-1:0] c);
        return c <= CNT_W'(AE_THRESH);
    endfunction

    // A write at full is legal only when paired with a read, which frees the slot.
    always_comb begin
        rd_ok      = re & ~empty;
        wr_ok      = we & (~full | re);
        count_next = next_count(count, wr_ok, rd_ok);
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
            dout         <= '0;
        end else if (clr) begin
            // Flush keeps the last word on dout.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                dout   <= mem[rd_ptr];
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= is_full(count_next);
            almost_empty <= is_almost_empty(count_next);
            almost_full  <= is_almost_full(count_next);
            wr_err       <= we & full & ~re;
            rd_err       <= re & empty;
        end
    end

endmodule
